shift_exec_stage: RTL and testbench

Two-stage pipelined execute unit for the six MIPS shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV). It sits between the register-read stage and writeback, decodes the funct code, and selects the shift amount. Right shifts are implemented on the team's 32-bit combinational left shifter (amount[4:0], data[31:0] -> out) by bit-reversing the operand and the result. Results leave through a valid/ready handshake with full backpressure and flush support.

---
 rtl/shift_exec_if.sv | 24 ++
 rtl/shift_exec_stage.sv | 71 +++++++
 tb/tb_shift_exec_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_exec_if.sv
// shift_exec_if: op input, flush and result handshake bundle for shift_exec_stage
interface shift_exec_if;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [5:0] in_funct;
  logic [31:0] in_rt;
  logic [31:0] in_rs;
  logic [4:0] in_shamt;
  logic [4:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic [4:0] out_tag;
  logic out_err;
  modport master (
    output flush, in_valid, in_funct, in_rt, in_rs, in_shamt, in_tag, out_ready,
    input in_ready, out_valid, out_data, out_tag, out_err
  );
  modport slave (
    input flush, in_valid, in_funct, in_rt, in_rs, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage MIPS shift execute unit with valid/ready output
module lshift32 (
  input  logic [4:0]  amount,
  input  logic [31:0] data,
  output logic [31:0] out
);
  assign out = data << amount;
endmodule

module shift_exec_stage (
  input logic clk,
  input logic reset,
  shift_exec_if.slave bus
);
  function automatic logic [31:0] bitrev(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bitrev[i] = v[31-i];
  endfunction
  logic s1_valid, s1_right, s1_arith, s1_sign, s1_err;
  logic [4:0] s1_amt, s1_tag;
  logic [31:0] s1_opnd, sh, mask, res;
  logic out_valid, out_err;
  logic [31:0] out_data;
  logic [4:0] out_tag;
  logic s2_adv, s1_adv, legal;
  assign s2_adv = !out_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign legal = bus.in_funct inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
  lshift32 u_sh (.amount(s1_amt), .data(s1_opnd), .out(sh));
  lshift32 u_mask (.amount(s1_amt), .data(32'hFFFF_FFFF), .out(mask));
  // right shifts run reversed through the left shifter; the reversed mask gives the sign fill
  always_comb res = s1_err ? '0 :
    ((s1_right ? bitrev(sh) : sh) | (s1_arith && s1_sign ? ~bitrev(mask) : '0));
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
      out_err <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_amt <= bus.in_funct[2] ? bus.in_rs[4:0] : bus.in_shamt;
          s1_right <= bus.in_funct[1];
          s1_arith <= &bus.in_funct[1:0];
          s1_sign <= bus.in_rt[31];
          s1_opnd <= bus.in_funct[1] ? bitrev(bus.in_rt) : bus.in_rt;
          s1_err <= !legal;
          s1_tag <= bus.in_tag;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res;
          out_tag <= s1_tag;
          out_err <= s1_err;
        end
      end
    end
  end
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_tag = out_tag;
  assign bus.out_err = out_err;
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb_shift_exec_stage: directed plus random checks of shift_exec_stage against a scoreboard
module tb_shift_exec_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  shift_exec_if bus ();
  shift_exec_stage dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [37:0] sbq[$];

  function automatic logic [37:0] model(logic [5:0] f, logic [31:0] rt, logic [31:0] rs,
                                        logic [4:0] sh, logic [4:0] tg);
    logic [4:0] amt;
    logic [31:0] d;
    logic e;
    amt = f[2] ? rs[4:0] : sh;
    e = 1'b0;
    case (f)
      6'd0, 6'd4: d = rt << amt;
      6'd2, 6'd6: d = rt >> amt;
      6'd3, 6'd7: d = $unsigned($signed(rt) >>> amt);
      default: begin d = '0; e = 1'b1; end
    endcase
    return {e, tg, d};
  endfunction

  task automatic chk(string name, logic [37:0] got, logic [37:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [5:0] f, logic [31:0] rt, logic [31:0] rs,
                       logic [4:0] sh, logic [4:0] tg);
    bus.in_valid = v;
    bus.in_funct = f;
    bus.in_rt = rt;
    bus.in_rs = rs;
    bus.in_shamt = sh;
    bus.in_tag = tg;
  endtask

  task automatic one(string name, logic [5:0] f, logic [31:0] rt, logic [31:0] rs,
                     logic [4:0] sh, logic [4:0] tg, logic [31:0] exp, logic e);
    drive(1'b1, f, rt, rs, sh, tg);
    step();
    bus.in_valid = 1'b0;
    chk({name, "_lat"}, bus.out_valid, 0);
    step();
    chk({name, "_v"}, bus.out_valid, 1);
    chk(name, {bus.out_err, bus.out_tag, bus.out_data}, {e, tg, exp});
    step();
  endtask

  task automatic drain(string name);
    for (int c = 0; c < 20 && (sbq.size() != 0 || bus.out_valid); c++) step();
    chk({name, "_q"}, 38'(sbq.size()), 0);
    chk({name, "_v"}, bus.out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (reset) sbq.delete();
    else begin
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $error("FAIL sb_unexpected got %h exp none",
                 {bus.out_err, bus.out_tag, bus.out_data});
        end else begin
          logic [37:0] e;
          e = sbq.pop_front();
          assert ({bus.out_err, bus.out_tag, bus.out_data} === e) else begin
            fails++;
            $error("FAIL sb_out got %h exp %h", {bus.out_err, bus.out_tag, bus.out_data}, e);
          end
        end
      end
      if (bus.flush) sbq.delete();
      else if (bus.in_valid && bus.in_ready)
        sbq.push_back(model(bus.in_funct, bus.in_rt, bus.in_rs, bus.in_shamt, bus.in_tag));
    end
  end

  initial begin
    logic [5:0] fl[8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd1, 6'h2b};
    int acc;
    int k;
    logic took;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 6'd0, 0, 0, 0, 0);
    repeat (2) step();
    reset = 1'b0;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_err", bus.out_err, 0);

    one("sll", 6'd0, 32'h1, 0, 5'd31, 5'd1, 32'h8000_0000, 1'b0);
    one("sra", 6'd3, 32'h8000_0000, 0, 5'd4, 5'd2, 32'hF800_0000, 1'b0);
    one("srl", 6'd2, 32'h8000_0000, 0, 5'd4, 5'd3, 32'h0800_0000, 1'b0);
    one("srav", 6'd7, 32'h7FFF_FFF0, 32'hFFFF_FF24, 5'd9, 5'd4, 32'h07FF_FFFF, 1'b0);
    one("sra0", 6'd3, 32'h8000_0001, 0, 5'd0, 5'd5, 32'h8000_0001, 1'b0);
    one("illegal", 6'h20, 32'h1234_5678, 0, 5'd3, 5'd6, 32'h0, 1'b1);
    one("srlv", 6'd6, 32'hF000_0000, 32'h1C, 5'd0, 5'd7, 32'h0000_000F, 1'b0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'd4, 32'h1, 32'(i), 5'd0, 5'(i));
      chk("stream_rdy", bus.in_ready, 1);
      step();
      if (i > 0)
        chk("stream", {bus.out_valid, bus.out_tag, bus.out_data}, {1'b1, 5'(i - 1), 32'(1) << (i - 1)});
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_last", {bus.out_valid, bus.out_tag, bus.out_data}, {1'b1, 5'd7, 32'h80});
    drain("stream_drain");

    bus.out_ready = 1'b0;
    acc = 0;
    k = 0;
    drive(1'b1, 6'd0, 32'h3, 0, 5'd0, 5'd10);
    repeat (5) begin
      took = bus.in_ready;
      step();
      if (took) begin
        acc++;
        k++;
        drive(1'b1, 6'd0, 32'h3, 0, 5'(k), 5'(10 + k));
      end
    end
    chk("bp_accepts", 38'(acc), 2);
    chk("bp_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("bp_drain");

    bus.out_ready = 1'b0;
    drive(1'b1, 6'd0, 32'h1, 0, 5'd1, 5'd20);
    step();
    drive(1'b1, 6'd0, 32'h1, 0, 5'd2, 5'd21);
    step();
    drive(1'b1, 6'd0, 32'h1, 0, 5'd3, 5'd31);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ready", bus.in_ready, 1);
    drive(1'b1, 6'd0, 32'h1, 0, 5'd4, 5'd30);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("flush_drop", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    one("post_flush", 6'd0, 32'h5, 0, 5'd1, 5'd22, 32'hA, 1'b0);

    bus.out_ready = 1'b0;
    drive(1'b1, 6'd2, 32'hFF, 0, 5'd1, 5'd23);
    step();
    drive(1'b1, 6'd2, 32'hFF, 0, 5'd2, 5'd24);
    step();
    drive(1'b1, 6'd2, 32'hFF, 0, 5'd3, 5'd25);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_stall_valid", bus.out_valid, 0);
    chk("rst_stall_ready", bus.in_ready, 1);
    repeat (4) step();
    chk("rst_stall_idle", bus.out_valid, 0);

    for (int c = 0; c < 200; c++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      if (!(bus.in_valid && !bus.in_ready))
        drive($urandom_range(0, 3) != 0, fl[$urandom_range(0, 7)], $urandom, $urandom,
              5'($urandom), 5'($urandom));
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
